// File: rtl/uart_seq_pkg.sv
// Shared constants, state encodings and the sequence-detector transition function.
// Latency: n/a (declarations and pure combinational function only).
// Backpressure: n/a; the bit stream has no flow control.
package uart_seq_pkg;

    localparam int CLK_FREQ  = 25_000_000;
    localparam int BAUD_RATE = 115200;
    localparam int DIV       = CLK_FREQ / BAUD_RATE;   // 217 clocks per bit
    localparam int HALF_DIV  = DIV / 2;                // 108 clocks to mid start bit
    localparam int CNT_W     = $clog2(DIV);

    // Bit 3 is the oldest bit of the sequence, bit 0 the newest.
    localparam logic [3:0] PATTERN = 4'b0101;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    // Sn = the last n bits seen equal the first (oldest) n bits of PATTERN.
    typedef enum logic [2:0] {S0, S1, S2, S3, S4} det_state_t;

    // Next detector state: the longest PATTERN prefix that is a suffix of the
    // currently matched prefix extended by the new bit. This gives the overlapping
    // behaviour for any PATTERN (for 0101: S4 + 0 -> S3, S4 + 1 -> S0).
    function automatic det_state_t det_next(input det_state_t s, input logic b);
        logic [7:0] seq;
        logic [2:0] len;
        logic [2:0] best;
        logic       ok;
        seq = '0;
        for (int j = 0; j < 4; j++) begin
            if (j < int'(s)) seq[j] = PATTERN[3-j];
        end
        seq[s] = b;
        len    = s + 3'd1;
        best   = '0;
        for (int k = 1; k <= 4; k++) begin
            if (k <= int'(len)) begin
                ok = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    if (i < k && seq[int'(len) - k + i] != PATTERN[3-i]) ok = 1'b0;
                end
                if (ok) best = 3'(k);
            end
        end
        return det_state_t'(best);
    endfunction

endpackage

// File: rtl/uart_seq_detect_rx.sv
// 8N1 UART receiver: synchronises rx and emits each data bit as a one-cycle strobe.
// Latency: strobe registered one cycle after the mid-bit sample (2 sync flops ahead).
// Backpressure: none; strobes are fire-and-forget, the consumer must always accept.
module uart_rx_bit
    import uart_seq_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic bit_valid,
    output logic bit_data
);

    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DIV - 1);

    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic             bit_valid_q, bit_valid_d;
    logic             bit_data_q, bit_data_d;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection; idles high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // RX FSM state, bit timer, bit index and registered strobe outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            bit_valid_q <= 1'b0;
            bit_data_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            bit_valid_q <= bit_valid_d;
            bit_data_q  <= bit_data_d;
        end
    end

    // Frame sequencing: only a fresh 1->0 edge arms a frame, so a line left low
    // after a framing error stays ignored until it returns high and falls again.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        bit_valid_d = 1'b0;
        bit_data_d  = bit_data_q;
        unique case (state_q)
            IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_sync_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d       = '0;
                    bit_valid_d = 1'b1;
                    bit_data_d  = rx_sync_q;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                    else                   bit_idx_d = bit_idx_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                // Stop bit value is not checked: emitted bits stand either way.
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bit_valid = bit_valid_q;
    assign bit_data  = bit_data_q;

endmodule

// File: rtl/uart_seq_detect_top.sv
// UART bit stream sequence detector: pulses match_pulse on each (overlapping) PATTERN hit.
// Latency: match_pulse and last4_debug update the cycle after the completing bit strobe.
// Backpressure: none; the serial line cannot be stalled.
module uart_seq_detect_top
    import uart_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       match_pulse,
    output logic       data_valid_debug,
    output logic       data_bit_debug,
    output logic [3:0] last4_debug
);

    logic       bit_valid;
    logic       bit_data;
    logic [3:0] last4_q;
    logic       upd_q;
    det_state_t det_q, det_d;

    uart_rx_bit u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .bit_valid (bit_valid),
        .bit_data  (bit_data)
    );

    // Shift history and detector state; history runs on across frames.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last4_q <= '0;
            upd_q   <= 1'b0;
            det_q   <= S0;
        end else begin
            upd_q <= bit_valid;
            det_q <= det_d;
            if (bit_valid) last4_q <= {last4_q[2:0], bit_data};
        end
    end

    // Detector next state: advances only on bit strobes.
    always_comb begin
        det_d = det_q;
        if (bit_valid) det_d = det_next(det_q, bit_data);
    end

    // Moore output, gated to the single cycle following a strobe.
    assign match_pulse      = (det_q == S4) && upd_q;
    assign data_valid_debug = bit_valid;
    assign data_bit_debug   = bit_data;
    assign last4_debug      = last4_q;

endmodule

// File: tb/tb_uart_seq_detect_top.sv
// Directed bench for the UART sequence detector with hand-computed expectations.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_seq_detect_top;

    localparam int CLK_NS = 40;
    localparam int BIT_NS = 8680;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic       match_pulse;
    logic       data_valid_debug;
    logic       data_bit_debug;
    logic [3:0] last4_debug;

    int n_chk  = 0;
    int n_fail = 0;

    int   strobe_cnt    = 0;
    int   match_cnt     = 0;
    int   last_match_at = 0;
    int   bad_match     = 0;
    logic prev_vld      = 1'b0;
    logic bit_log [0:255];

    int s0, m0;

    uart_seq_detect_top dut (
        .clk              (clk),
        .rst              (rst),
        .rx               (rx),
        .match_pulse      (match_pulse),
        .data_valid_debug (data_valid_debug),
        .data_bit_debug   (data_bit_debug),
        .last4_debug      (last4_debug)
    );

    always #(CLK_NS/2) clk = ~clk;

    // Monitor on the falling edge: log strobed bits, count matches and note
    // any match that does not directly follow a strobe.
    always @(negedge clk) begin
        if (match_pulse) begin
            match_cnt++;
            last_match_at = strobe_cnt;
            if (!prev_vld) bad_match++;
        end
        if (data_valid_debug) begin
            bit_log[strobe_cnt[7:0]] = data_bit_debug;
            strobe_cnt++;
        end
        prev_vld = data_valid_debug;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] log_byte(input int base);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = bit_log[(base + i) % 256];
        return b;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(BIT_NS);
        end
        rx = stop;
        #(BIT_NS);
        rx = 1'b1;
    endtask

    task automatic chk_outputs_zero(input string pfx);
        chk({pfx, "_match"}, 32'(match_pulse), 32'd0);
        chk({pfx, "_vld"},   32'(data_valid_debug), 32'd0);
        chk({pfx, "_bit"},   32'(data_bit_debug), 32'd0);
        chk({pfx, "_last4"}, 32'(last4_debug), 32'd0);
    endtask

    initial begin
        // Reset for 5 cycles, then 2 idle bit periods.
        rst = 1'b0;
        rx  = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        rst = 1'b1;
        #(2*BIT_NS);

        // 0xA5: bits 1,0,1,0,0,1,0,1 -> single match on the 8th bit.
        s0 = strobe_cnt; m0 = match_cnt;
        send_byte(8'hA5, 1'b1);
        #(BIT_NS);
        chk("a5_strobes", 32'(strobe_cnt - s0), 32'd8);
        chk("a5_byte",    32'(log_byte(s0)), 32'hA5);
        chk("a5_matches", 32'(match_cnt - m0), 32'd1);
        chk("a5_match_pos", 32'(last_match_at - s0), 32'd8);
        chk("a5_last4",   32'(last4_debug), 32'h5);

        // 0xF5 continues the stream: match on the 5th bit, history ends 1111.
        s0 = strobe_cnt; m0 = match_cnt;
        send_byte(8'hF5, 1'b1);
        #(BIT_NS);
        chk("f5_strobes", 32'(strobe_cnt - s0), 32'd8);
        chk("f5_byte",    32'(log_byte(s0)), 32'hF5);
        chk("f5_matches", 32'(match_cnt - m0), 32'd1);
        chk("f5_match_pos", 32'(last_match_at - s0), 32'd5);
        chk("f5_last4",   32'(last4_debug), 32'hF);

        // Reset, then 0x0A: match on 4th bit, trailing 0,1,0 overlap gives no second hit.
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #(2*BIT_NS);
        s0 = strobe_cnt; m0 = match_cnt;
        send_byte(8'h0A, 1'b1);
        #(BIT_NS);
        chk("0a_strobes", 32'(strobe_cnt - s0), 32'd8);
        chk("0a_byte",    32'(log_byte(s0)), 32'h0A);
        chk("0a_matches", 32'(match_cnt - m0), 32'd1);
        chk("0a_match_pos", 32'(last_match_at - s0), 32'd4);
        chk("0a_last4",   32'(last4_debug), 32'h0);

        // Short low glitch on the idle line: rejected at mid start bit.
        s0 = strobe_cnt; m0 = match_cnt;
        rx = 1'b0;
        #(50*CLK_NS);
        rx = 1'b1;
        #(2*BIT_NS);
        chk("glitch_strobes", 32'(strobe_cnt - s0), 32'd0);
        chk("glitch_matches", 32'(match_cnt - m0), 32'd0);

        // Reset part-way through 0xA5 (during data bit 3).
        rx = 1'b0;
        #(BIT_NS);
        rx = 1'b1; #(BIT_NS);
        rx = 1'b0; #(BIT_NS);
        rx = 1'b1; #(BIT_NS);
        rx = 1'b0; #(100*CLK_NS);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_outputs_zero("midrst");
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        s0 = strobe_cnt; m0 = match_cnt;
        #(12*BIT_NS);
        chk("midrst_strobes", 32'(strobe_cnt - s0), 32'd0);
        chk("midrst_matches", 32'(match_cnt - m0), 32'd0);
        chk("midrst_last4_after", 32'(last4_debug), 32'h0);

        // 0x3C with a bad stop bit, then 0xA5: both received, matches at bits 11 and 16.
        s0 = strobe_cnt; m0 = match_cnt;
        send_byte(8'h3C, 1'b0);
        #(2*BIT_NS);
        send_byte(8'hA5, 1'b1);
        #(BIT_NS);
        chk("ferr_strobes", 32'(strobe_cnt - s0), 32'd16);
        chk("ferr_byte1",   32'(log_byte(s0)), 32'h3C);
        chk("ferr_byte2",   32'(log_byte(s0 + 8)), 32'hA5);
        chk("ferr_matches", 32'(match_cnt - m0), 32'd2);
        chk("ferr_match_pos", 32'(last_match_at - s0), 32'd16);
        chk("ferr_last4",   32'(last4_debug), 32'h5);

        // Every match must have followed a strobe by exactly one cycle.
        chk("match_after_strobe", 32'(bad_match), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
